// File: rtl/mips32_pkg.sv
// ----------------------------------------------------------------------------
// mips32_pkg
// Shared definitions for the MIPS32 memory subsystem.
//   - DEFAULT_ADDR_W     : default memory word-address width (1024 words)
//   - DEFAULT_STARVE_MAX : default number of consecutive denied fetch cycles
//                          tolerated before the fetch port is forced through
//   - resp_owner_t       : which port owns the read response returning in the
//                          cycle after a grant
// ----------------------------------------------------------------------------
package mips32_pkg;

  localparam int DEFAULT_ADDR_W     = 10;
  localparam int DEFAULT_STARVE_MAX = 3;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_DM   = 2'd2
  } resp_owner_t;

endpackage

// File: rtl/pipe_mem_arbiter.sv
// ----------------------------------------------------------------------------
// pipe_mem_arbiter
// Shares one single-port synchronous memory between the instruction-fetch (if)
// port and the data (dm) port of a pipelined MIPS32 core. One access per
// cycle; data wins ties unless fetch has been denied STARVE_MAX cycles in a
// row. Read data returns one cycle after the grant and is routed to whichever
// port was granted; stores complete at the grant and produce no response.
//
// Ports
//   clk1, rst            : clock, synchronous active-high reset
//   if_req/if_addr       : fetch request and word address
//   if_gnt               : fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata   : fetched word, valid one cycle after if_gnt
//   dm_req/dm_we/dm_addr/dm_wdata : load/store request
//   dm_gnt               : data request accepted this cycle (combinational)
//   dm_rvalid/dm_rdata   : load data, valid one cycle after a load grant
//   halted               : processor halted, no new fetch grants
//   mem_en/mem_we/mem_addr/mem_wdata : memory strobe, driven combinationally
//   mem_rdata            : memory read data, one cycle after a read strobe
//
// ADDR_W must be in 1..31; upper address bits are dropped (addresses wrap).
// ----------------------------------------------------------------------------
module pipe_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  input  logic              halted,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_next;
  resp_owner_t      resp_owner;
  resp_owner_t      resp_owner_next;
  logic [31:0]      if_rdata_hold;
  logic [31:0]      dm_rdata_hold;
  logic             if_win;
  logic             dm_win;

  // Only the low ADDR_W address bits reach memory; fold the rest away.
  if (ADDR_W < 32) begin : g_unused_addr
    logic unused_upper_addr;
    assign unused_upper_addr = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};
  end

  // Arbitration: data first, fetch forced once the starvation limit is hit.
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (rst) begin
      if_win = 1'b0;
      dm_win = 1'b0;
    end else begin
      if (if_req && !halted && (!dm_req || (starve_cnt == STARVE_LIMIT))) begin
        if_win = 1'b1;
      end else begin
        if_win = 1'b0;
      end
      if (dm_req && !if_win) begin
        dm_win = 1'b1;
      end else begin
        dm_win = 1'b0;
      end
    end
  end

  assign if_gnt = if_win;
  assign dm_gnt = dm_win;

  // Memory strobe built from the winning requester; quiet when idle.
  always_comb begin
    mem_en    = if_win | dm_win;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = 32'h0000_0000;
    if (dm_win) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr[ADDR_W-1:0];
      mem_wdata = dm_wdata;
    end else if (if_win) begin
      mem_addr  = if_addr[ADDR_W-1:0];
    end else begin
      mem_we    = 1'b0;
    end
  end

  // Next starvation count and next response owner.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (if_win || !if_req) begin
      starve_cnt_next = {CNT_W{1'b0}};
    end else if (!halted && (starve_cnt != STARVE_LIMIT)) begin
      starve_cnt_next = starve_cnt + CNT_ONE;
    end else begin
      // Halted fetches neither age nor reset; saturate at the limit.
      starve_cnt_next = starve_cnt;
    end

    resp_owner_next = OWNER_NONE;
    if (if_win) begin
      resp_owner_next = OWNER_IF;
    end else if (dm_win && !dm_we) begin
      resp_owner_next = OWNER_DM;
    end else begin
      resp_owner_next = OWNER_NONE;
    end
  end

  // State registers: starvation counter, response owner, held read data.
  always_ff @(posedge clk1) begin
    if (rst) begin
      starve_cnt    <= {CNT_W{1'b0}};
      resp_owner    <= OWNER_NONE;
      if_rdata_hold <= 32'h0000_0000;
      dm_rdata_hold <= 32'h0000_0000;
    end else begin
      starve_cnt <= starve_cnt_next;
      resp_owner <= resp_owner_next;
      if (if_rvalid) begin
        if_rdata_hold <= mem_rdata;
      end
      if (dm_rvalid) begin
        dm_rdata_hold <= mem_rdata;
      end
    end
  end

  // Response routing; reset kills a response that was due this cycle.
  always_comb begin
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if (rst) begin
      if_rvalid = 1'b0;
      dm_rvalid = 1'b0;
    end else begin
      case (resp_owner)
        OWNER_IF: if_rvalid = 1'b1;
        OWNER_DM: dm_rvalid = 1'b1;
        default: begin
          if_rvalid = 1'b0;
          dm_rvalid = 1'b0;
        end
      endcase
    end
    // Memory data passes straight through in the valid cycle, then is held.
    if_rdata = if_rvalid ? mem_rdata : if_rdata_hold;
    dm_rdata = dm_rvalid ? mem_rdata : dm_rdata_hold;
  end

endmodule
